// File: rtl/pci_addr_decoder_if.sv
// ----------------------------------------------------------------------------
// pci_addr_decoder_if
// Bundles the PCI bus signals seen by the target address decoder together
// with the decoder's results.
//
//   frame        FRAME#, active-low
//   irdy         IRDY#, active-low
//   ad           AD bus
//   cbe          C/BE# bus, command during the address phase
//   decoderInput claim speed to the DEVSEL# stage (0/1/2 claim, 3 no claim)
//   hit          1 while the current transaction is claimed
//   cmd          latched bus command
//   addr         latched address, advanced per completed data phase
//   is_write     latched write-class flag
//   trans_active 1 from the address phase until the bus is idle
//
// Modports:
//   slave  - the decoder: samples the bus, drives the results
//   master - the bus side: drives the bus, observes the results
// ----------------------------------------------------------------------------
interface pci_addr_decoder_if;
    logic        frame;
    logic        irdy;
    logic [31:0] ad;
    logic [3:0]  cbe;
    logic [1:0]  decoderInput;
    logic        hit;
    logic [3:0]  cmd;
    logic [31:0] addr;
    logic        is_write;
    logic        trans_active;

    modport slave (
        input  frame,
        input  irdy,
        input  ad,
        input  cbe,
        output decoderInput,
        output hit,
        output cmd,
        output addr,
        output is_write,
        output trans_active
    );

    modport master (
        output frame,
        output irdy,
        output ad,
        output cbe,
        input  decoderInput,
        input  hit,
        input  cmd,
        input  addr,
        input  is_write,
        input  trans_active
    );
endinterface

// File: rtl/pci_addr_decoder.sv
// ----------------------------------------------------------------------------
// pci_addr_decoder
// PCI target address-phase decoder feeding the DEVSEL# generator. Detects the
// address phase, latches command and address, compares them against the
// memory BAR and holds the claim result for the whole transaction.
//
// Ports:
//   clk  - PCI clock, all state changes on posedge
//   RST  - asynchronous active-low reset
//   bus  - pci_addr_decoder_if.slave (frame, irdy, ad, cbe in;
//          decoderInput, hit, cmd, addr, is_write, trans_active out)
//
// Optional feature: define PCI_IO_SPACE_EN to also decode I/O commands
// (0010/0011) against the IO_BASE / IO_SIZE_LOG2 window. I/O transactions
// latch the full byte address and do not advance addr. Without the macro the
// I/O parameters and compare logic do not exist and I/O commands never hit.
//
// DECODE_SPEED must be 0, 1 or 2; 3 would read as "no claim" downstream.
//
// FSM states:
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | bus idle, decoderInput follows the live decode of ad/cbe
//   CLAIMED   | transaction decoded as ours, tracking data phases
//   IGNORED   | foreign transaction, tracking data phases without a claim
//   WAIT_IDLE | last data phase done; wait for idle or a back-to-back start
// ----------------------------------------------------------------------------
module pci_addr_decoder #(
    parameter logic [31:0] BAR_BASE      = 32'h0000_1000,
    parameter int unsigned BAR_SIZE_LOG2 = 4,
    parameter logic [1:0]  DECODE_SPEED  = 2'd1
`ifdef PCI_IO_SPACE_EN
    ,
    parameter logic [31:0] IO_BASE       = 32'h0000_0100,
    parameter int unsigned IO_SIZE_LOG2  = 3
`endif
) (
    input  logic               clk,
    input  logic               RST,
    pci_addr_decoder_if.slave  bus
);

    localparam logic [1:0]  NO_CLAIM = 2'd3;
    localparam logic [31:0] BAR_MASK = ~((32'd1 << BAR_SIZE_LOG2) - 32'd1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CLAIMED   = 2'd1,
        IGNORED   = 2'd2,
        WAIT_IDLE = 2'd3
    } state_t;

    state_t      stateQ, stateNext;
    logic        hitQ, hitNext;
    logic [3:0]  cmdQ, cmdNext;
    logic [31:0] addrQ, addrNext;
    logic        isWriteQ, isWriteNext;
    logic        activeQ, activeNext;
    logic [1:0]  decodeQ, decodeNext;
    logic        ioTxnQ, ioTxnNext;
    logic [1:0]  decoderOut;

    // ------------------------------------------------------------------
    // Live decode of the current ad/cbe, used on address-phase cycles
    // ------------------------------------------------------------------
    logic        memCmd;
    logic        memWrite;
    logic        memHit;
    logic        ioCmd;
    logic        ioWrite;
    logic        ioHit;
    logic [1:0]  decodeNow;
    logic [31:0] latchAddr;
    logic        addrPhase;

    always_comb begin
        memCmd = 1'b0;
        case (bus.cbe)
            4'b0110, 4'b0111, 4'b1100, 4'b1110, 4'b1111: memCmd = 1'b1;
            default:                                     memCmd = 1'b0;
        endcase
    end

    assign memWrite = (bus.cbe == 4'b0111) || (bus.cbe == 4'b1111);
    assign memHit   = memCmd && ((bus.ad & BAR_MASK) == (BAR_BASE & BAR_MASK));

`ifdef PCI_IO_SPACE_EN
    localparam logic [31:0] IO_MASK = ~((32'd1 << IO_SIZE_LOG2) - 32'd1);

    assign ioCmd   = (bus.cbe == 4'b0010) || (bus.cbe == 4'b0011);
    assign ioWrite = (bus.cbe == 4'b0011);
    assign ioHit   = ioCmd && ((bus.ad & IO_MASK) == (IO_BASE & IO_MASK));
`else
    assign ioCmd   = 1'b0;
    assign ioWrite = 1'b0;
    assign ioHit   = 1'b0;
`endif

    assign decodeNow = (memHit || ioHit) ? DECODE_SPEED : NO_CLAIM;

    // Memory addresses are dword aligned; I/O keeps the byte address.
    assign latchAddr = ioCmd ? bus.ad : {bus.ad[31:2], 2'b00};

    // WAIT_IDLE with frame low is a back-to-back start and decodes as IDLE.
    assign addrPhase = !bus.frame && ((stateQ == IDLE) || (stateQ == WAIT_IDLE));

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        stateNext   = stateQ;
        hitNext     = hitQ;
        cmdNext     = cmdQ;
        addrNext    = addrQ;
        isWriteNext = isWriteQ;
        activeNext  = activeQ;
        decodeNext  = decodeQ;
        ioTxnNext   = ioTxnQ;
        decoderOut  = decodeQ;

        case (stateQ)
            IDLE: begin
                decoderOut = bus.frame ? NO_CLAIM : decodeNow;
            end

            CLAIMED, IGNORED: begin
                if (!bus.irdy) begin
                    if (!ioTxnQ) begin
                        addrNext = addrQ + 32'd4;
                    end
                    if (bus.frame) begin
                        stateNext = WAIT_IDLE;
                    end
                end else if (bus.frame) begin
                    // Master abort or early exit: no data phase completed.
                    stateNext  = IDLE;
                    hitNext    = 1'b0;
                    activeNext = 1'b0;
                    decodeNext = NO_CLAIM;
                end
            end

            WAIT_IDLE: begin
                if (!bus.frame) begin
                    decoderOut = decodeNow;
                end else if (bus.irdy) begin
                    stateNext  = IDLE;
                    hitNext    = 1'b0;
                    activeNext = 1'b0;
                    decodeNext = NO_CLAIM;
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase

        if (addrPhase) begin
            cmdNext     = bus.cbe;
            addrNext    = latchAddr;
            isWriteNext = memWrite || ioWrite;
            decodeNext  = decodeNow;
            ioTxnNext   = ioCmd;
            activeNext  = 1'b1;
            if (memHit || ioHit) begin
                hitNext   = 1'b1;
                stateNext = CLAIMED;
            end else begin
                hitNext   = 1'b0;
                stateNext = IGNORED;
            end
        end

        // Reset is asynchronous, so the claim must drop without a clock.
        if (!RST) begin
            decoderOut = NO_CLAIM;
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            stateQ   <= IDLE;
            hitQ     <= 1'b0;
            cmdQ     <= 4'd0;
            addrQ    <= 32'd0;
            isWriteQ <= 1'b0;
            activeQ  <= 1'b0;
            decodeQ  <= NO_CLAIM;
            ioTxnQ   <= 1'b0;
        end else begin
            stateQ   <= stateNext;
            hitQ     <= hitNext;
            cmdQ     <= cmdNext;
            addrQ    <= addrNext;
            isWriteQ <= isWriteNext;
            activeQ  <= activeNext;
            decodeQ  <= decodeNext;
            ioTxnQ   <= ioTxnNext;
        end
    end

    assign bus.decoderInput = decoderOut;
    assign bus.hit          = hitQ;
    assign bus.cmd          = cmdQ;
    assign bus.addr         = addrQ;
    assign bus.is_write     = isWriteQ;
    assign bus.trans_active = activeQ;

endmodule

// File: tb/tb_pci_addr_decoder.sv
// ----------------------------------------------------------------------------
// tb_pci_addr_decoder
// Directed bench for pci_addr_decoder. Two instances share one stimulus:
// busA uses the default BAR at 0x0000_1000, busB places the BAR at the top of
// the address space to exercise address wrap. Inputs change on the falling
// edge; combinational outputs are read 1 ns later, registered outputs 1 ns
// after the rising edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pci_addr_decoder;

    logic        clk;
    logic        RST;
    logic        frame;
    logic        irdy;
    logic [31:0] ad;
    logic [3:0]  cbe;

    int nChecks = 0;
    int nFails  = 0;

    pci_addr_decoder_if busA ();
    pci_addr_decoder_if busB ();

    assign busA.frame = frame;
    assign busA.irdy  = irdy;
    assign busA.ad    = ad;
    assign busA.cbe   = cbe;
    assign busB.frame = frame;
    assign busB.irdy  = irdy;
    assign busB.ad    = ad;
    assign busB.cbe   = cbe;

    pci_addr_decoder dutA (
        .clk (clk),
        .RST (RST),
        .bus (busA)
    );

    pci_addr_decoder #(
        .BAR_BASE      (32'hFFFF_FFF0),
        .BAR_SIZE_LOG2 (4),
        .DECODE_SPEED  (2'd1)
    ) dutB (
        .clk (clk),
        .RST (RST),
        .bus (busB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic f, input logic i, input logic [31:0] a, input logic [3:0] c);
        @(negedge clk);
        frame = f;
        irdy  = i;
        ad    = a;
        cbe   = c;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        RST   = 1'b0;
        frame = 1'b1;
        irdy  = 1'b1;
        ad    = 32'h0;
        cbe   = 4'h0;
        #2;
        checkEq("rst_dec",    {30'd0, busA.decoderInput}, 32'd3);
        checkEq("rst_hit",    {31'd0, busA.hit}, 32'd0);
        checkEq("rst_addr",   busA.addr, 32'd0);
        checkEq("rst_cmd",    {28'd0, busA.cmd}, 32'd0);
        checkEq("rst_active", {31'd0, busA.trans_active}, 32'd0);
        checkEq("rst_wr",     {31'd0, busA.is_write}, 32'd0);

        // frame low while in reset is not an address phase
        drive(1'b0, 1'b1, 32'h0000_1004, 4'b0111);
        checkEq("rstfrm_dec", {30'd0, busA.decoderInput}, 32'd3);
        tick();
        checkEq("rstfrm_hit",    {31'd0, busA.hit}, 32'd0);
        checkEq("rstfrm_active", {31'd0, busA.trans_active}, 32'd0);

        @(negedge clk);
        frame = 1'b1;
        RST   = 1'b1;

        // idle bus
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 32'h0000_1000, 4'b0110);
            checkEq("idle_dec", {30'd0, busA.decoderInput}, 32'd3);
            tick();
            checkEq("idle_hit",    {31'd0, busA.hit}, 32'd0);
            checkEq("idle_active", {31'd0, busA.trans_active}, 32'd0);
        end

        // memory write hit, single data phase
        drive(1'b0, 1'b1, 32'h0000_1004, 4'b0111);
        checkEq("mw_dec_ap", {30'd0, busA.decoderInput}, 32'd1);
        tick();
        checkEq("mw_hit",    {31'd0, busA.hit}, 32'd1);
        checkEq("mw_wr",     {31'd0, busA.is_write}, 32'd1);
        checkEq("mw_addr0",  busA.addr, 32'h0000_1004);
        checkEq("mw_cmd",    {28'd0, busA.cmd}, 32'h7);
        checkEq("mw_active", {31'd0, busA.trans_active}, 32'd1);
        drive(1'b1, 1'b0, 32'hDEAD_BEEF, 4'b0000);
        checkEq("mw_dec_dp", {30'd0, busA.decoderInput}, 32'd1);
        tick();
        checkEq("mw_addr1",  busA.addr, 32'h0000_1008);
        checkEq("mw_hit_wi", {31'd0, busA.hit}, 32'd1);
        drive(1'b1, 1'b1, 32'h0, 4'h0);
        checkEq("mw_dec_wi", {30'd0, busA.decoderInput}, 32'd1);
        tick();
        checkEq("mw_hit_end",    {31'd0, busA.hit}, 32'd0);
        checkEq("mw_active_end", {31'd0, busA.trans_active}, 32'd0);
        checkEq("mw_dec_end",    {30'd0, busA.decoderInput}, 32'd3);

        // memory read miss, 3 data phases; data looks like a BAR hit
        drive(1'b0, 1'b1, 32'h0000_2000, 4'b0110);
        checkEq("mr_dec_ap", {30'd0, busA.decoderInput}, 32'd3);
        tick();
        checkEq("mr_hit0",    {31'd0, busA.hit}, 32'd0);
        checkEq("mr_active0", {31'd0, busA.trans_active}, 32'd1);
        checkEq("mr_addr0",   busA.addr, 32'h0000_2000);
        checkEq("mr_wr",      {31'd0, busA.is_write}, 32'd0);
        for (int k = 1; k <= 3; k++) begin
            drive((k == 3), 1'b0, 32'h0000_1004, 4'b0111);
            checkEq("mr_dec_dp", {30'd0, busA.decoderInput}, 32'd3);
            tick();
            checkEq("mr_hit",    {31'd0, busA.hit}, 32'd0);
            checkEq("mr_active", {31'd0, busA.trans_active}, 32'd1);
            checkEq("mr_addr",   busA.addr, 32'h0000_2000 + 32'(4 * k));
        end
        drive(1'b1, 1'b1, 32'h0, 4'h0);
        tick();
        checkEq("mr_active_end", {31'd0, busA.trans_active}, 32'd0);

        // address wrap on the top-of-space BAR (busB)
        drive(1'b0, 1'b1, 32'hFFFF_FFFC, 4'b0110);
        checkEq("wrap_dec_ap", {30'd0, busB.decoderInput}, 32'd1);
        tick();
        checkEq("wrap_hit",   {31'd0, busB.hit}, 32'd1);
        checkEq("wrap_addr0", busB.addr, 32'hFFFF_FFFC);
        drive(1'b0, 1'b0, 32'h0, 4'h0);
        tick();
        checkEq("wrap_addr1", busB.addr, 32'h0000_0000);
        drive(1'b1, 1'b0, 32'h0, 4'h0);
        tick();
        checkEq("wrap_addr2", busB.addr, 32'h0000_0004);
        drive(1'b1, 1'b1, 32'h0, 4'h0);
        tick();
        checkEq("wrap_hit_end", {31'd0, busB.hit}, 32'd0);

        // back-to-back: WAIT_IDLE straight into a new address phase
        drive(1'b0, 1'b1, 32'h0000_1008, 4'b0111);
        tick();
        drive(1'b1, 1'b0, 32'h0, 4'h0);
        tick();
        checkEq("b2b_addr1", busA.addr, 32'h0000_100C);
        drive(1'b0, 1'b1, 32'h0000_1000, 4'b0110);
        checkEq("b2b_dec_ap", {30'd0, busA.decoderInput}, 32'd1);
        tick();
        checkEq("b2b_hit",    {31'd0, busA.hit}, 32'd1);
        checkEq("b2b_addr",   busA.addr, 32'h0000_1000);
        checkEq("b2b_cmd",    {28'd0, busA.cmd}, 32'h6);
        checkEq("b2b_wr",     {31'd0, busA.is_write}, 32'd0);
        checkEq("b2b_active", {31'd0, busA.trans_active}, 32'd1);
        drive(1'b1, 1'b0, 32'h0, 4'h0);
        tick();
        checkEq("b2b_addr2", busA.addr, 32'h0000_1004);
        drive(1'b1, 1'b1, 32'h0, 4'h0);
        tick();
        checkEq("b2b_hit_end", {31'd0, busA.hit}, 32'd0);

        // master abort: frame released with irdy never asserted
        drive(1'b0, 1'b1, 32'h0000_100C, 4'b1100);
        tick();
        checkEq("ma_hit", {31'd0, busA.hit}, 32'd1);
        drive(1'b1, 1'b1, 32'h0, 4'h0);
        tick();
        checkEq("ma_hit_end",    {31'd0, busA.hit}, 32'd0);
        checkEq("ma_active_end", {31'd0, busA.trans_active}, 32'd0);
        checkEq("ma_addr",       busA.addr, 32'h0000_100C);
        checkEq("ma_dec_end",    {30'd0, busA.decoderInput}, 32'd3);

        // reset pulsed during a claimed burst
        drive(1'b0, 1'b1, 32'h0000_1000, 4'b0110);
        tick();
        drive(1'b0, 1'b0, 32'h0, 4'h0);
        tick();
        checkEq("mid_addr_pre", busA.addr, 32'h0000_1004);
        @(negedge clk);
        RST = 1'b0;
        #1;
        checkEq("mid_hit",    {31'd0, busA.hit}, 32'd0);
        checkEq("mid_addr",   busA.addr, 32'd0);
        checkEq("mid_cmd",    {28'd0, busA.cmd}, 32'd0);
        checkEq("mid_active", {31'd0, busA.trans_active}, 32'd0);
        checkEq("mid_dec",    {30'd0, busA.decoderInput}, 32'd3);
        tick();
        checkEq("mid_hit_rst", {31'd0, busA.hit}, 32'd0);
        @(negedge clk);
        RST = 1'b1;
        ad  = 32'h0000_1008;
        cbe = 4'b0111;
        #1;
        checkEq("post_dec_ap", {30'd0, busA.decoderInput}, 32'd1);
        tick();
        checkEq("post_hit",  {31'd0, busA.hit}, 32'd1);
        checkEq("post_addr", busA.addr, 32'h0000_1008);
        checkEq("post_wr",   {31'd0, busA.is_write}, 32'd1);
        drive(1'b1, 1'b0, 32'h0, 4'h0);
        tick();
        drive(1'b1, 1'b1, 32'h0, 4'h0);
        tick();
        checkEq("post_hit_end", {31'd0, busA.hit}, 32'd0);

        // I/O write at 0x102: claimed only with the I/O feature built in
        drive(1'b0, 1'b1, 32'h0000_0102, 4'b0011);
`ifdef PCI_IO_SPACE_EN
        checkEq("io_dec_ap", {30'd0, busA.decoderInput}, 32'd1);
        tick();
        checkEq("io_hit",   {31'd0, busA.hit}, 32'd1);
        checkEq("io_wr",    {31'd0, busA.is_write}, 32'd1);
        checkEq("io_addr0", busA.addr, 32'h0000_0102);
        drive(1'b0, 1'b0, 32'h0, 4'h0);
        tick();
        checkEq("io_addr1", busA.addr, 32'h0000_0102);
        drive(1'b1, 1'b0, 32'h0, 4'h0);
        tick();
        checkEq("io_addr2", busA.addr, 32'h0000_0102);
`else
        checkEq("io_dec_ap", {30'd0, busA.decoderInput}, 32'd3);
        tick();
        checkEq("io_hit",    {31'd0, busA.hit}, 32'd0);
        checkEq("io_active", {31'd0, busA.trans_active}, 32'd1);
        checkEq("io_addr0",  busA.addr, 32'h0000_0100);
        drive(1'b1, 1'b0, 32'h0, 4'h0);
        tick();
        checkEq("io_addr1", busA.addr, 32'h0000_0104);
`endif
        drive(1'b1, 1'b1, 32'h0, 4'h0);
        tick();
        checkEq("io_active_end", {31'd0, busA.trans_active}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
